// File: rtl/mem_pkg.sv
// mem_pkg: shared widths and FSM state encoding for the memory access controller and its RAM
package mem_pkg;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 9;
    localparam int MEM_DEPTH = 512;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2, RESP = 2'd3} state_e;
endpackage

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: serialises one CPU load/store at a time onto a 1-cycle-latency synchronous RAM
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W    = mem_pkg::DATA_W,
    parameter int ADDR_W    = mem_pkg::ADDR_W,
    parameter int MEM_DEPTH = mem_pkg::MEM_DEPTH
) (
    input  logic              clk_i,
    input  logic              clear_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              resp_err_o,
    output logic              ram_read_o,
    output logic              ram_write_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

    state_e            state_q;
    logic              write_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              in_range;

    assign in_range = {1'b0, req_addr_i} < DEPTH;

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid_i) begin
                    addr_q  <= req_addr_i;
                    wdata_q <= req_wdata_i;
                    write_q <= req_write_i;
                    err_q   <= ~in_range;
                    state_q <= in_range ? ISSUE : RESP;
                end
                ISSUE:   state_q <= write_q ? RESP : CAPTURE;
                CAPTURE: begin
                    rdata_q <= ram_rdata_i;
                    state_q <= RESP;
                end
                RESP: if (resp_ready_i) begin
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Strobes come straight from the state register, so they can never overlap
    assign req_ready_o  = state_q == IDLE;
    assign resp_valid_o = state_q == RESP;
    assign resp_err_o   = err_q;
    assign resp_rdata_o = rdata_q;
    assign ram_read_o   = (state_q == ISSUE) & ~write_q;
    assign ram_write_o  = (state_q == ISSUE) & write_q;
    assign ram_addr_o   = addr_q;
    assign ram_wdata_o  = wdata_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed stimulus, latency-based transaction model and literal checks
module tb_mem_access_ctrl;
    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
    logic [8:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, ram_read, ram_write;
    logic [31:0] resp_rdata, ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic [8:0]  ram_addr;

    logic        r2_valid = 1'b0, r2_ready = 1'b1;
    logic [8:0]  r2_addr = '0;
    logic        q2_ready, v2_valid, e2_err, rd2, wr2;
    logic [31:0] d2_rdata, w2_data;
    logic [8:0]  a2_addr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk_i(clk), .clear_i(clear), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata),
        .resp_err_o(resp_err), .ram_read_o(ram_read), .ram_write_o(ram_write),
        .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    mem_access_ctrl #(.MEM_DEPTH(256)) dut2 (
        .clk_i(clk), .clear_i(clear), .req_valid_i(r2_valid), .req_ready_o(q2_ready),
        .req_write_i(1'b0), .req_addr_i(r2_addr), .req_wdata_i(32'h0),
        .resp_valid_o(v2_valid), .resp_ready_i(r2_ready), .resp_rdata_o(d2_rdata),
        .resp_err_o(e2_err), .ram_read_o(rd2), .ram_write_o(wr2),
        .ram_addr_o(a2_addr), .ram_wdata_o(w2_data), .ram_rdata_i(32'h0)
    );

    logic [31:0] mem [512];
    always @(posedge clk) begin
        if (ram_write) mem[ram_addr] <= ram_wdata;
        if (ram_read) ram_rdata <= mem[ram_addr];
    end

    task automatic ck(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: latency in edges counted from the accept edge
    logic [31:0] shadow [512];
    bit          model_ok = 0, busy = 0, t_write = 0, t_err = 0;
    int          age = 0, lat = 0;
    logic [8:0]  m_addr = '0;
    logic [31:0] m_wdata = '0, exp_rdata = '0, ld_val = '0;

    always @(posedge clk) begin
        if (clear) begin
            busy = 0; exp_rdata = '0; m_addr = '0; m_wdata = '0; model_ok = 1;
        end else if (!busy) begin
            if (req_valid) begin
                busy = 1; age = 1; t_write = req_write;
                t_err = int'(req_addr) >= 512;
                lat = t_err ? 1 : (t_write ? 2 : 3);
                m_addr = req_addr; m_wdata = req_wdata;
                ld_val = shadow[req_addr];
                if (t_write && !t_err) shadow[req_addr] = req_wdata;
            end
        end else if (age >= lat && resp_ready) begin
            busy = 0;
        end else begin
            age++;
            if (age == 3 && !t_write && !t_err) exp_rdata = ld_val;
        end
    end

    always @(negedge clk) if (model_ok) begin
        ck("m_req_ready", 32'(req_ready), 32'(!busy));
        ck("m_resp_valid", 32'(resp_valid), 32'(busy && age >= lat));
        ck("m_resp_err", 32'(resp_err), 32'(busy && t_err));
        ck("m_resp_rdata", resp_rdata, exp_rdata);
        ck("m_ram_read", 32'(ram_read), 32'(busy && !t_err && !t_write && age == 1));
        ck("m_ram_write", 32'(ram_write), 32'(busy && !t_err && t_write && age == 1));
        ck("m_ram_addr", 32'(ram_addr), 32'(m_addr));
        ck("m_ram_wdata", ram_wdata, m_wdata);
    end

    task automatic issue(input logic w, input logic [8:0] a, input logic [31:0] d);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        logic [8:0] err_addrs [3];
        for (int i = 0; i < 512; i++) begin
            mem[i] = '0;
            shadow[i] = '0;
        end
        repeat (2) @(negedge clk);
        ck("rst_req_ready", 32'(req_ready), 32'd1);
        ck("rst_resp_valid", 32'(resp_valid), 32'd0);
        ck("rst_resp_err", 32'(resp_err), 32'd0);
        ck("rst_rdata", resp_rdata, 32'd0);
        ck("rst_strobes", 32'({ram_read, ram_write}), 32'd0);
        ck("rst_ram_addr", 32'(ram_addr), 32'd0);
        ck("rst_ram_wdata", ram_wdata, 32'd0);
        clear = 1'b0;

        issue(1'b1, 9'd144, 32'hDEADBEEF);
        ck("st_ram_write", 32'(ram_write), 32'd1);
        ck("st_ram_addr", 32'(ram_addr), 32'd144);
        ck("st_ram_wdata", ram_wdata, 32'hDEADBEEF);
        ck("st_early_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        ck("st_write_once", 32'(ram_write), 32'd0);
        ck("st_resp_valid", 32'(resp_valid), 32'd1);
        ck("st_resp_err", 32'(resp_err), 32'd0);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        ck("st_back_idle", 32'(req_ready), 32'd1);

        issue(1'b0, 9'd144, 32'h0);
        ck("ld_ram_read", 32'(ram_read), 32'd1);
        ck("ld_no_write", 32'(ram_write), 32'd0);
        @(negedge clk);
        ck("ld_read_once", 32'(ram_read), 32'd0);
        ck("ld_early_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        ck("ld_resp_valid", 32'(resp_valid), 32'd1);
        ck("ld_rdata", resp_rdata, 32'hDEADBEEF);
        resp_ready = 1'b1;
        @(negedge clk);

        issue(1'b1, 9'd247, 32'h12345678);
        repeat (2) @(negedge clk);
        ck("fast_idle", 32'(req_ready), 32'd1);
        resp_ready = 1'b0;

        issue(1'b0, 9'd247, 32'h0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            ck("stall_valid", 32'(resp_valid), 32'd1);
            ck("stall_rdata", resp_rdata, 32'h12345678);
            ck("stall_req_ready", 32'(req_ready), 32'd0);
            if (i == 1) begin
                req_valid = 1'b1; req_write = 1'b1; req_addr = 9'd247; req_wdata = 32'hBAD0BAD0;
            end
            if (i == 2) req_valid = 1'b0;
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        ck("stall_done_ready", 32'(req_ready), 32'd1);
        ck("stall_done_valid", 32'(resp_valid), 32'd0);
        issue(1'b0, 9'd247, 32'h0);
        repeat (2) @(negedge clk);
        ck("ignored_store", resp_rdata, 32'h12345678);
        @(negedge clk);

        issue(1'b1, 9'd511, 32'hA5A5A5A5);
        repeat (2) @(negedge clk);
        issue(1'b0, 9'd511, 32'h0);
        repeat (2) @(negedge clk);
        ck("top_addr_rdata", resp_rdata, 32'hA5A5A5A5);
        @(negedge clk);

        err_addrs[0] = 9'd300; err_addrs[1] = 9'd256; err_addrs[2] = 9'd255;
        for (int i = 0; i < 3; i++) begin
            r2_valid = 1'b1; r2_addr = err_addrs[i];
            @(negedge clk);
            r2_valid = 1'b0;
            ck("d2_valid", 32'(v2_valid), 32'(i < 2));
            ck("d2_err", 32'(e2_err), 32'(i < 2));
            ck("d2_read", 32'(rd2), 32'(i == 2));
            ck("d2_write", 32'(wr2), 32'd0);
            repeat (i < 2 ? 1 : 3) @(negedge clk);
            ck("d2_idle", 32'(q2_ready), 32'd1);
            ck("d2_err_clear", 32'(e2_err), 32'd0);
        end

        issue(1'b0, 9'd144, 32'h0);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        ck("clr_ready", 32'(req_ready), 32'd1);
        ck("clr_valid", 32'(resp_valid), 32'd0);
        ck("clr_read", 32'(ram_read), 32'd0);
        repeat (2) begin
            @(negedge clk);
            ck("clr_no_resp", 32'(resp_valid), 32'd0);
        end
        issue(1'b0, 9'd144, 32'h0);
        repeat (2) @(negedge clk);
        ck("clr_reload_valid", 32'(resp_valid), 32'd1);
        ck("clr_reload_rdata", resp_rdata, 32'hDEADBEEF);
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
